// File: rtl/sp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_pkg
// Description : Shared bank FSM state type and width helpers for the banked
//               single-port RAM wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package sp_ram_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        AWAKE = 2'd0,
        SLEEP = 2'd1,
        WAKE  = 2'd2
    } bank_state_e;

    // Index width that never collapses to zero, so single-entry selects stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned bank_count(input int unsigned ram_size,
                                               input int unsigned bank_depth,
                                               input int unsigned data_width);
        return ram_size / (bank_depth * (data_width / BYTE_W));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram_bank.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_bank
// Description : One RAM bank: DATA_WIDTH/8 byte-wide macros plus the optional
//               idle-sleep FSM (compiled in with SP_RAM_SLEEP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_bank
    import sp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BANK_DEPTH  = 2048,
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rstn_i,
    input  logic                            req_i,
    input  logic                            we_i,
    input  logic [DATA_WIDTH/8-1:0]         be_i,
    input  logic [idx_width(BANK_DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    input  logic                            bypass_en_i,
    output logic                            gnt_o,
    output logic                            sleep_o,
    output logic [DATA_WIDTH-1:0]           rdata_o
);

    localparam int unsigned BYTES = DATA_WIDTH / BYTE_W;

    generate
        if (IDLE_CYCLES < 1 || WAKE_CYCLES < 1) begin : g_cfg_invalid
        end
    endgenerate

`ifdef SP_RAM_SLEEP_EN
    localparam int unsigned IDLE_W = idx_width(IDLE_CYCLES);
    localparam int unsigned WAKE_W = idx_width(WAKE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    bank_state_e         state_q, state_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [WAKE_W-1:0]   wake_q, wake_d;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= AWAKE;
            idle_q  <= '0;
            wake_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
        end
    end

    // The request cycle seen in SLEEP counts as the first wake cycle.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        case (state_q)
            AWAKE: begin
                if (req_i) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = SLEEP;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            SLEEP: begin
                if (req_i) begin
                    if (WAKE_CYCLES == 1) begin
                        state_d = AWAKE;
                    end else begin
                        state_d = WAKE;
                        wake_d  = WAKE_W'(1);
                    end
                end
            end
            WAKE: begin
                if (wake_q == WAKE_LAST) begin
                    state_d = AWAKE;
                    wake_d  = '0;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            default: begin
                state_d = AWAKE;
                idle_d  = '0;
                wake_d  = '0;
            end
        endcase
    end

    assign gnt_o   = req_i && (state_q == AWAKE);
    assign sleep_o = (state_q != AWAKE);
`else
    logic unused_rstn;
    assign unused_rstn = rstn_i;
    assign gnt_o       = req_i;
    assign sleep_o     = 1'b0;
`endif

    // Byte macros are selected only on a grant, so a sleeping bank stays idle.
    generate
        for (genvar b = 0; b < BYTES; b++) begin : g_byte
            logic [BYTE_W-1:0] mem_q [BANK_DEPTH];
            logic [BYTE_W-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (gnt_o) begin
                    if (we_i && be_i[b]) begin
                        mem_q[waddr_i] <= wdata_i[BYTE_W*b +: BYTE_W];
                    end
                    // Test bypass routes write data straight to the output latch.
                    if (!we_i) begin
                        dout_q <= bypass_en_i ? wdata_i[BYTE_W*b +: BYTE_W] : mem_q[waddr_i];
                    end
                end
            end

            assign rdata_o[BYTE_W*b +: BYTE_W] = dout_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sp_ram_banked_wrap.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_banked_wrap
// Description : Banked single-port RAM with one-cycle response and optional
//               per-bank idle sleep (macro SP_RAM_SLEEP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_banked_wrap
    import sp_ram_pkg::*;
#(
    parameter int unsigned RAM_SIZE    = 32768,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BANK_DEPTH  = 2048,
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rstn_i,
    input  logic                          req_i,
    output logic                          gnt_o,
    input  logic [$clog2(RAM_SIZE)-1:0]   addr_i,
    input  logic                          we_i,
    input  logic [DATA_WIDTH/8-1:0]       be_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    output logic                          rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    input  logic                          bypass_en_i,
    output logic [bank_count(RAM_SIZE, BANK_DEPTH, DATA_WIDTH)-1:0] bank_sleep_o
);

    localparam int unsigned BYTES      = DATA_WIDTH / BYTE_W;
    localparam int unsigned ADDR_W     = $clog2(RAM_SIZE);
    localparam int unsigned BYTE_BITS  = $clog2(BYTES);
    localparam int unsigned WORD_BITS  = idx_width(BANK_DEPTH);
    localparam int unsigned BANK_COUNT = bank_count(RAM_SIZE, BANK_DEPTH, DATA_WIDTH);
    localparam int unsigned BANK_BITS  = $clog2(BANK_COUNT);
    localparam int unsigned SEL_W      = idx_width(BANK_COUNT);

    logic [SEL_W-1:0]      bank_idx;
    logic [WORD_BITS-1:0]  word_addr;
    logic [BANK_COUNT-1:0] bank_req;
    logic [BANK_COUNT-1:0] bank_gnt;
    logic [DATA_WIDTH-1:0] bank_rdata [BANK_COUNT];

    logic                  rvalid_q;
    logic                  rwe_q;
    logic [SEL_W-1:0]      rbank_q;

    generate
        if (BANK_BITS > 0) begin : g_bank_idx
            assign bank_idx = addr_i[ADDR_W-1 -: BANK_BITS];
        end else begin : g_single_bank
            assign bank_idx = '0;
        end

        if (BYTE_BITS > 0) begin : g_byte_lsb
            logic unused_lsb;
            assign unused_lsb = ^addr_i[BYTE_BITS-1:0];
        end
    endgenerate

    assign word_addr = addr_i[BYTE_BITS +: WORD_BITS];

    generate
        for (genvar n = 0; n < BANK_COUNT; n++) begin : g_bank
            assign bank_req[n] = req_i && (bank_idx == SEL_W'(n));

            sp_ram_bank #(
                .DATA_WIDTH  (DATA_WIDTH),
                .BANK_DEPTH  (BANK_DEPTH),
                .IDLE_CYCLES (IDLE_CYCLES),
                .WAKE_CYCLES (WAKE_CYCLES)
            ) u_bank (
                .clk         (clk),
                .rstn_i      (rstn_i),
                .req_i       (bank_req[n]),
                .we_i        (we_i),
                .be_i        (be_i),
                .waddr_i     (word_addr),
                .wdata_i     (wdata_i),
                .bypass_en_i (bypass_en_i),
                .gnt_o       (bank_gnt[n]),
                .sleep_o     (bank_sleep_o[n]),
                .rdata_o     (bank_rdata[n])
            );
        end
    endgenerate

    assign gnt_o = |bank_gnt;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_q <= 1'b0;
            rwe_q    <= 1'b0;
            rbank_q  <= '0;
        end else begin
            rvalid_q <= gnt_o;
            if (gnt_o) begin
                rwe_q   <= we_i;
                rbank_q <= bank_idx;
            end
        end
    end

    // Write responses and idle cycles return zero data.
    always_comb begin
        rdata_o = '0;
        if (rvalid_q && !rwe_q) begin
            for (int n = 0; n < int'(BANK_COUNT); n++) begin
                if (rbank_q == SEL_W'(n)) begin
                    rdata_o = bank_rdata[n];
                end
            end
        end
    end

    assign rvalid_o = rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_banked_wrap.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_banked_wrap
// Description : Randomized self-checking bench with a byte-array reference
//               model; sleep expectations follow SP_RAM_SLEEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_banked_wrap;

    localparam int unsigned RAM_SIZE    = 32768;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned BANK_DEPTH  = 2048;
    localparam int unsigned IDLE_CYCLES = 16;
    localparam int unsigned WAKE_CYCLES = 2;
    localparam int NB  = 4;
    localparam int WIN = 16;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        req_i;
    logic        gnt_o;
    logic [14:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        bypass_en_i;
    logic [3:0]  bank_sleep_o;

    always #5 clk = ~clk;

    sp_ram_banked_wrap #(
        .RAM_SIZE    (RAM_SIZE),
        .DATA_WIDTH  (DATA_WIDTH),
        .BANK_DEPTH  (BANK_DEPTH),
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES)
    ) dut (
        .clk          (clk),
        .rstn_i       (rstn_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .bypass_en_i  (bypass_en_i),
        .bank_sleep_o (bank_sleep_o)
    );

    // Reference model state
    logic [7:0]  mem_m [RAM_SIZE];
    bit          sleeping_m [NB];
    int          idle_m [NB];
    int          wake_m [NB];
    bit          pend_v;
    logic [31:0] pend_d;
    int          cyc;
    logic [31:0] last_rdata;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NB; n++) begin
            sleeping_m[n] = 1'b0;
            idle_m[n]     = 0;
            wake_m[n]     = -1;
        end
        pend_v = 1'b0;
        pend_d = '0;
    endtask

    // One clock: drive, compare against model, then advance the model past the edge.
    task automatic step(input bit req, input logic [14:0] addr, input bit we,
                        input logic [3:0] be, input logic [31:0] wd, output bit granted);
        int b;
        int base;
        bit eg;
        logic [3:0] exp_sleep;
        @(negedge clk);
        req_i   = req;
        addr_i  = addr;
        we_i    = we;
        be_i    = be;
        wdata_i = wd;
        #1;
        b  = int'(addr[14:13]);
        eg = req && !sleeping_m[b];
        for (int n = 0; n < NB; n++) exp_sleep[n] = sleeping_m[n];
        check("gnt", 32'(gnt_o), 32'(eg));
        check("bank_sleep", 32'(bank_sleep_o), 32'(exp_sleep));
        check("rvalid", 32'(rvalid_o), 32'(pend_v));
        check("rdata", rdata_o, pend_v ? pend_d : 32'h0);
        last_rdata = rdata_o;

        pend_v = eg;
        pend_d = '0;
        if (eg) begin
            base = int'({addr[14:2], 2'b00});
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mem_m[base + k] = wd[8*k +: 8];
                end
            end else begin
                pend_d = {mem_m[base + 3], mem_m[base + 2], mem_m[base + 1], mem_m[base]};
            end
        end
`ifdef SP_RAM_SLEEP_EN
        for (int n = 0; n < NB; n++) begin
            if (!sleeping_m[n]) begin
                if (eg && b == n) begin
                    idle_m[n] = 0;
                end else begin
                    idle_m[n]++;
                    if (idle_m[n] >= int'(IDLE_CYCLES)) begin
                        sleeping_m[n] = 1'b1;
                        idle_m[n]     = 0;
                        wake_m[n]     = -1;
                    end
                end
            end else begin
                if (wake_m[n] < 0 && req && b == n) wake_m[n] = cyc;
                if (wake_m[n] >= 0 && (cyc + 1 - wake_m[n]) >= int'(WAKE_CYCLES)) begin
                    sleeping_m[n] = 1'b0;
                    wake_m[n]     = -1;
                    idle_m[n]     = 0;
                end
            end
        end
`endif
        cyc++;
        granted = eg;
    endtask

    task automatic xfer(input logic [14:0] addr, input bit we, input logic [3:0] be,
                        input logic [31:0] wd, output int tries);
        bit g;
        tries = 0;
        do begin
            step(1'b1, addr, we, be, wd, g);
            tries++;
        end while (!g && tries < 50);
        if (!g) check("grant_timeout", 32'(gnt_o), 32'd1);
    endtask

    task automatic idle(input int n);
        bit g;
        for (int i = 0; i < n; i++) step(1'b0, 15'h0, 1'b0, 4'h0, 32'h0, g);
    endtask

    task automatic init_mem();
        int t;
        logic [1:0] bs;
        for (int bk = 0; bk < NB; bk++) begin
            bs = 2'(bk);
            for (int w = 0; w < WIN; w++) begin
                xfer({bs, 11'(w), 2'b00}, 1'b1, 4'hF, $urandom, t);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        bit          g;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] exp3;
        logic [1:0]  bs;
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        rstn_i      = 1'b0;
        req_i       = 1'b0;
        addr_i      = '0;
        we_i        = 1'b0;
        be_i        = '0;
        wdata_i     = '0;
        bypass_en_i = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_sleep", 32'(bank_sleep_o), 32'h0);
        check("rst_gnt_idle", 32'(gnt_o), 32'd0);
        @(negedge clk);
        rstn_i = 1'b1;

        init_mem();

        xfer(15'h0000, 1'b1, 4'hF, 32'hDEADBEEF, t);
        xfer(15'h0000, 1'b0, 4'h0, 32'h0, t);
        idle(1);
        check("full_word_rdata", last_rdata, 32'hDEADBEEF);

        xfer(15'h2004, 1'b1, 4'hF, 32'hFFFFFFFF, t);
        xfer(15'h2004, 1'b1, 4'h5, 32'h11223344, t);
        xfer(15'h2004, 1'b0, 4'h0, 32'h0, t);
        idle(1);
        check("byte_enable_rdata", last_rdata, 32'hFF22FF44);

        step(1'b1, 15'h0000, 1'b0, 4'h0, 32'h0, g);
        step(1'b1, 15'h2000, 1'b0, 4'h0, 32'h0, g);
        r0 = last_rdata;
        idle(1);
        r1 = last_rdata;
        check("b2b_bank0", r0, 32'hDEADBEEF);
        check("b2b_bank1", r1, {mem_m[16'h2003], mem_m[16'h2002], mem_m[16'h2001], mem_m[16'h2000]});

        // Reset while a read response is on the bus.
        step(1'b1, 15'h0000, 1'b0, 4'h0, 32'h0, g);
        @(negedge clk);
        req_i = 1'b0;
        #1;
        rstn_i = 1'b0;
        #1;
        check("rst_mid_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_mid_rdata", rdata_o, 32'h0);
        @(posedge clk);
        #2;
        rstn_i = 1'b1;
        model_reset();
        idle(1);

`ifdef SP_RAM_SLEEP_EN
        init_mem();
        idle(IDLE_CYCLES + 4);
        check("bank3_asleep", 32'(bank_sleep_o[3]), 32'd1);
        exp3 = {mem_m[16'h6003], mem_m[16'h6002], mem_m[16'h6001], mem_m[16'h6000]};
        xfer(15'h6000, 1'b0, 4'h0, 32'h0, t);
        check("wake_tries", 32'(t), 32'd3);
        idle(1);
        check("wake_retained", last_rdata, exp3);

        idle(IDLE_CYCLES + 2);
        step(1'b1, 15'h4000, 1'b1, 4'hF, 32'hA5A5A5A5, g);
        @(negedge clk);
        req_i = 1'b0;
        #1;
        check("bank2_waking", 32'(bank_sleep_o[2]), 32'd1);
        rstn_i = 1'b0;
        #1;
        check("rst_wake_sleep", 32'(bank_sleep_o), 32'h0);
        check("rst_wake_rvalid", 32'(rvalid_o), 32'd0);
        @(posedge clk);
        #2;
        rstn_i = 1'b1;
        model_reset();
        step(1'b1, 15'h4000, 1'b1, 4'hF, 32'h5A5A5A5A, g);
        check("rst_wake_regrant", 32'(gnt_o), 32'd1);
`else
        idle(100);
        step(1'b1, 15'h6000, 1'b1, 4'hF, 32'h0BADF00D, g);
        check("nosleep_gnt", 32'(gnt_o), 32'd1);
        check("nosleep_sleep", 32'(bank_sleep_o), 32'h0);
`endif

        init_mem();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(int'($urandom_range(1, 24)));
            end else begin
                bs = 2'($urandom_range(0, 3));
                xfer({bs, 11'($urandom_range(0, WIN - 1)), 2'($urandom_range(0, 3))},
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, t);
            end
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sp_ram_banked_wrap.md
SP_RAM_BANKED_WRAP -- requirements
Module: sp_ram_banked_wrap

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 32768, total bytes (power of two).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width (multiple of 8).
REQ-003 SHALL have parameter BANK_DEPTH, default 2048, words per bank; BANK_COUNT = RAM_SIZE/(BANK_DEPTH*DATA_WIDTH/8), power of two, >=1.
REQ-004 SHALL have parameter IDLE_CYCLES, default 16, idle cycles before a bank sleeps (>=1).
REQ-005 SHALL have parameter WAKE_CYCLES, default 2, cycles from wake start to bank usable (>=1).
REQ-006 clk  input  1  clock, rising edge.
REQ-007 rstn_i  input  1  asynchronous active-low reset.
REQ-008 req_i  input  1  access request.
REQ-009 gnt_o  output  1  request accepted this cycle.
REQ-010 addr_i  input  $clog2(RAM_SIZE)  byte address; low $clog2(DATA_WIDTH/8) bits ignored.
REQ-011 we_i  input  1  1 = write, 0 = read.
REQ-012 be_i  input  DATA_WIDTH/8  byte enables for writes.
REQ-013 wdata_i  input  DATA_WIDTH  write data.
REQ-014 rvalid_o  output  1  response for request granted previous cycle.
REQ-015 rdata_o  output  DATA_WIDTH  read data, qualified by rvalid_o.
REQ-016 bypass_en_i  input  1  macro test bypass, passed to all macros.
REQ-017 bank_sleep_o  output  BANK_COUNT  per-bank sleep status.

Function
REQ-018 Bank index SHALL be addr_i[MSB : word_bits+byte_bits]; word address addr_i[word_bits+byte_bits-1 : byte_bits].
REQ-019 gnt_o SHALL be combinational: req_i AND addressed bank in AWAKE.
REQ-020 Only a granted access SHALL assert chip select on the addressed bank; byte macro write-enabled iff we_i and be_i[b].
REQ-021 rvalid_o SHALL assert exactly one cycle after each grant (reads and writes), latency 1, back-to-back grants allowed every cycle.
REQ-022 Granted bank index and we_i SHALL be registered; rdata_o SHALL mux that bank's macro outputs for reads, and SHALL be all-zero when rvalid_o is low or the response is for a write.
REQ-023 Each bank SHALL run an FSM: AWAKE -> SLEEP after IDLE_CYCLES consecutive cycles without a grant to it; SLEEP -> WAKE on req_i addressing it; WAKE -> AWAKE after WAKE_CYCLES cycles.
REQ-024 Idle counter SHALL saturate, clear on any grant to its bank, and only count in AWAKE.
REQ-025 Request to a bank in SLEEP or WAKE SHALL see gnt_o low; requester holds req_i and addr_i stable until granted.
REQ-026 req_i dropped during WAKE SHALL not abort wake; bank reaches AWAKE and restarts idle count.
REQ-027 bank_sleep_o[n] SHALL be 1 in SLEEP and WAKE, 0 in AWAKE; a bank in SLEEP SHALL hold its macros deselected (contents retained).
REQ-028 Grant to bank n SHALL not affect idle counters of other banks.

Reset
REQ-029 Asynchronous assertion SHALL force: all banks AWAKE, idle counters 0, wake counters 0, rvalid_o 0, rdata_o 0, registered bank select 0, bank_sleep_o 0.
REQ-030 Reset mid-wake or mid-access SHALL abandon it; no response issued after reset; RAM contents undefined.

Configuration
REQ-031 Macro SP_RAM_SLEEP_EN SHALL compile in the sleep FSM, idle/wake counters and bank gating.
REQ-032 Without SP_RAM_SLEEP_EN: gnt_o = req_i, bank_sleep_o tied 0, IDLE_CYCLES/WAKE_CYCLES unused; all other behaviour identical.

Structure
REQ-033 Package sp_ram_pkg SHALL hold the bank FSM state enum (AWAKE, SLEEP, WAKE) and width-derivation helper constants.
REQ-034 Sub-module sp_ram_bank SHALL wrap one bank (DATA_WIDTH/8 byte-wide BANK_DEPTH macros plus its FSM); top instantiates BANK_COUNT copies and the response mux.

Verification
REQ-035 Write 0xDEADBEEF be=0xF addr 0x0000, read 0x0000 -> rvalid next cycle, rdata 0xDEADBEEF.
REQ-036 Write 0x11223344 be=0x5 over 0xFFFFFFFF at 0x2004, read -> 0xFF22FF44.
REQ-037 Back-to-back reads addr 0x0000 (bank0) then 0x2000 (bank1) -> consecutive rvalid, each rdata from correct bank.
REQ-038 Bank 3 untouched 16 cycles -> bank_sleep_o[3]=1; read 0x6000 -> gnt low 2 cycles, granted cycle 3, data retained.
REQ-039 Assert rstn_i low during bank-2 WAKE -> rvalid_o 0, bank_sleep_o 0 immediately; next request granted same cycle.
REQ-040 Build without SP_RAM_SLEEP_EN, 100 idle cycles then request -> gnt_o same cycle, bank_sleep_o stays 0.
